fir_stream_sequencer: RTL and testbench

//  Bus master sequencing the memory-mapped FIR slave (b=addr0, x=addr1, control=addr2; read addr1=y).
//  On start: loads NUM_TAPS coefficients from a coefficient ROM, then sets control=1.

---
 rtl/fir_stream_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_fir_stream_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_stream_sequencer.sv
// Bus master that loads FIR coefficients from a ROM, then streams samples through the FIR slave.
// Define FIR_SEQ_CNT_EN to add the sample_cnt output (completed output handshakes since start).
module fir_stream_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TAP_W      = 5,
  parameter int SETTLE_CYC = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [TAP_W-1:0]      num_taps,
  output logic [TAP_W-1:0]      coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_rdata,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  fir_cs,
  output logic                  fir_write,
  output logic                  fir_read,
  output logic [1:0]            fir_addr,
  output logic [DATA_WIDTH-1:0] fir_wdata,
  input  logic [DATA_WIDTH-1:0] fir_rdata,
  output logic                  busy
`ifdef FIR_SEQ_CNT_EN
  ,
  output logic [31:0]           sample_cnt
`endif
);

  localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam logic [1:0] ADDR_B    = 2'd0;
  localparam logic [1:0] ADDR_X    = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  typedef enum logic [3:0] {
    IDLE, COEF_RD, COEF_WR, CTRL_ON, WAIT_X, SETTLE, RD_Y, CAP_Y, OUT, CTRL_OFF
  } state_t;

  state_t                state_q, state_d;
  logic [TAP_W-1:0]      taps_q, taps_d;
  logic [TAP_W-1:0]      cnt_q, cnt_d;
  logic [TAP_W-1:0]      coef_addr_q, coef_addr_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  fir_cs_q, fir_cs_d;
  logic                  fir_write_q, fir_write_d;
  logic                  fir_read_q, fir_read_d;
  logic [1:0]            fir_addr_q, fir_addr_d;
  logic [DATA_WIDTH-1:0] fir_wdata_q, fir_wdata_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
`ifdef FIR_SEQ_CNT_EN
  logic [31:0]           sample_cnt_q, sample_cnt_d;
`endif

  // Bus strobes are registered, so a write decided in a state appears on the bus the following cycle;
  // the y read is launched from the last SETTLE cycle so it is on the bus while the FSM sits in RD_Y.
  always_comb begin
    state_d     = state_q;
    taps_d      = taps_q;
    cnt_d       = cnt_q;
    coef_addr_d = coef_addr_q;
    settle_d    = settle_q;
    stop_pend_d = stop_pend_q;
    fir_cs_d    = 1'b0;
    fir_write_d = 1'b0;
    fir_read_d  = 1'b0;
    fir_addr_d  = fir_addr_q;
    fir_wdata_d = fir_wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef FIR_SEQ_CNT_EN
    sample_cnt_d = sample_cnt_q;
`endif

    if (state_q != IDLE && stop) begin
      stop_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          taps_d      = num_taps;
          cnt_d       = '0;
          coef_addr_d = '0;
`ifdef FIR_SEQ_CNT_EN
          sample_cnt_d = '0;
`endif
          state_d     = (num_taps == '0) ? CTRL_ON : COEF_RD;
        end
      end
      COEF_RD: state_d = COEF_WR;
      COEF_WR: begin
        fir_cs_d    = 1'b1;
        fir_write_d = 1'b1;
        fir_addr_d  = ADDR_B;
        fir_wdata_d = coef_rdata;
        if (cnt_q == taps_q - TAP_W'(1)) begin
          state_d = CTRL_ON;
        end else begin
          cnt_d       = cnt_q + TAP_W'(1);
          coef_addr_d = coef_addr_q + TAP_W'(1);
          state_d     = COEF_RD;
        end
      end
      CTRL_ON: begin
        fir_cs_d    = 1'b1;
        fir_write_d = 1'b1;
        fir_addr_d  = ADDR_CTRL;
        fir_wdata_d = DATA_WIDTH'(1);
        state_d     = WAIT_X;
      end
      WAIT_X: begin
        if (in_valid) begin
          fir_cs_d    = 1'b1;
          fir_write_d = 1'b1;
          fir_addr_d  = ADDR_X;
          fir_wdata_d = in_data;
          settle_d    = '0;
          state_d     = SETTLE;
        end else if (stop_pend_q) begin
          state_d = CTRL_OFF;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC)) begin
          fir_cs_d   = 1'b1;
          fir_read_d = 1'b1;
          fir_addr_d = ADDR_X;
          state_d    = RD_Y;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      RD_Y: state_d = CAP_Y;
      CAP_Y: begin
        out_data_d  = fir_rdata;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
`ifdef FIR_SEQ_CNT_EN
          sample_cnt_d = sample_cnt_q + 32'd1;
`endif
          state_d     = WAIT_X;
        end
      end
      CTRL_OFF: begin
        fir_cs_d    = 1'b1;
        fir_write_d = 1'b1;
        fir_addr_d  = ADDR_CTRL;
        fir_wdata_d = '0;
        stop_pend_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      taps_q      <= '0;
      cnt_q       <= '0;
      coef_addr_q <= '0;
      settle_q    <= '0;
      stop_pend_q <= 1'b0;
      fir_cs_q    <= 1'b0;
      fir_write_q <= 1'b0;
      fir_read_q  <= 1'b0;
      fir_addr_q  <= '0;
      fir_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef FIR_SEQ_CNT_EN
      sample_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      taps_q      <= taps_d;
      cnt_q       <= cnt_d;
      coef_addr_q <= coef_addr_d;
      settle_q    <= settle_d;
      stop_pend_q <= stop_pend_d;
      fir_cs_q    <= fir_cs_d;
      fir_write_q <= fir_write_d;
      fir_read_q  <= fir_read_d;
      fir_addr_q  <= fir_addr_d;
      fir_wdata_q <= fir_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef FIR_SEQ_CNT_EN
      sample_cnt_q <= sample_cnt_d;
`endif
    end
  end

  assign coef_addr = coef_addr_q;
  assign in_ready  = (state_q == WAIT_X);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign fir_cs    = fir_cs_q;
  assign fir_write = fir_write_q;
  assign fir_read  = fir_read_q;
  assign fir_addr  = fir_addr_q;
  assign fir_wdata = fir_wdata_q;
  assign busy      = (state_q != IDLE);
`ifdef FIR_SEQ_CNT_EN
  assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Directed bench for fir_stream_sequencer with a coefficient ROM model and a FIR slave model (y = 2*x).
// Build with FIR_SEQ_CNT_EN defined to also exercise sample_cnt.
`timescale 1ns/1ps
module tb_fir_stream_sequencer;
  localparam int DW = 32;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n, start, stop, in_valid, out_ready;
  logic [TW-1:0] num_taps, coef_addr;
  logic [DW-1:0] coef_rdata = '0;
  logic [DW-1:0] in_data, out_data, fir_wdata;
  logic [DW-1:0] fir_rdata = '0;
  logic [DW-1:0] x_reg = '0;
  logic          in_ready, out_valid, fir_cs, fir_write, fir_read, busy;
  logic [1:0]    fir_addr;
`ifdef FIR_SEQ_CNT_EN
  logic [31:0]   sample_cnt;
`endif

  typedef struct { int cyc; logic rd; logic [1:0] addr; logic [DW-1:0] data; } bus_ev_t;
  typedef struct { logic [DW-1:0] x; int stall; logic [DW-1:0] y; } vec_t;

  bus_ev_t bus_log[$];
  int cyc = 0;
  int prot_err = 0;
  int checks = 0;
  int errors = 0;

  fir_stream_sequencer #(.DATA_WIDTH(DW), .TAP_W(TW), .SETTLE_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .num_taps(num_taps),
    .coef_addr(coef_addr), .coef_rdata(coef_rdata), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fir_cs(fir_cs), .fir_write(fir_write), .fir_read(fir_read), .fir_addr(fir_addr),
    .fir_wdata(fir_wdata), .fir_rdata(fir_rdata), .busy(busy)
`ifdef FIR_SEQ_CNT_EN
    , .sample_cnt(sample_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ROM holds 2*i+5, so taps 0..2 read back 5, 7, 9 one cycle after the address.
  always @(posedge clk) coef_rdata <= 32'(coef_addr) * 32'd2 + 32'd5;

  // FIR slave stand-in: remembers the last x write and answers reads with 2*x, registered.
  always @(posedge clk) begin
    if (fir_cs && fir_write && fir_addr == 2'd1) x_reg <= fir_wdata;
    if (fir_cs && fir_read) fir_rdata <= {x_reg[DW-2:0], 1'b0};
  end

  // Logs every bus strobe with the cycle it was visible in, and flags cs/strobe inconsistencies.
  always @(posedge clk) begin
    if (fir_write || fir_read) bus_log.push_back('{cyc, fir_read, fir_addr, fir_wdata});
    if ((fir_cs != (fir_write || fir_read)) || (fir_write && fir_read)) prot_err <= prot_err + 1;
    cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkEvent(input string name, input int idx, input int base, input int off,
                            input logic rd, input logic [1:0] addr, input logic [DW-1:0] data);
    logic [DW-1:0] got;
    if (idx >= bus_log.size()) begin
      checkOutput(name, 64'(bus_log.size()), 64'(idx + 1));
    end else begin
      got = rd ? '0 : bus_log[idx].data;
      checkOutput(name, {13'd0, 16'(bus_log[idx].cyc - base), bus_log[idx].rd, bus_log[idx].addr, got},
                  {13'd0, 16'(off), rd, addr, data});
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] x, output int hs_cyc);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    if (in_ready !== 1'b1) checkOutput("in_ready_timeout", 64'(in_ready), 1);
    hs_cyc   = cyc;
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic waitOutValid(input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    if (out_valid !== 1'b1) checkOutput(name, 64'(out_valid), 1);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin tick(); n++; end
    if (busy !== 1'b0) checkOutput(name, 64'(busy), 0);
  endtask

  task automatic checkCoefLoad3(input string tag);
    int k;
    bus_log.delete();
    k = cyc;
    start = 1'b1; num_taps = 5'd3;
    tick();
    start = 1'b0;
    checkOutput({tag, "_busy"}, 64'(busy), 1);
    tick(6);
    checkOutput({tag, "_ready_early"}, 64'(in_ready), 0);
    tick();
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 1);
    tick();
    checkOutput({tag, "_nev"}, 64'(bus_log.size()), 4);
    checkEvent({tag, "_b0"}, 0, k, 3, 1'b0, 2'd0, 32'd5);
    checkEvent({tag, "_b1"}, 1, k, 5, 1'b0, 2'd0, 32'd7);
    checkEvent({tag, "_b2"}, 2, k, 7, 1'b0, 2'd0, 32'd9);
    checkEvent({tag, "_ctrl_on"}, 3, k, 8, 1'b0, 2'd2, 32'd1);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t trio[3];
    int   hs, k;
    logic stable;

    vecs[0] = '{32'h0000_0001, 0, 32'h0000_0002};
    vecs[1] = '{32'h1234_5678, 1, 32'h2468_ACF0};
    vecs[2] = '{32'hA5A5_A5A5, 4, 32'h4B4B_4B4A};
    vecs[3] = '{32'h7FFF_FFFF, 0, 32'hFFFF_FFFE};
    vecs[4] = '{32'h8000_0001, 2, 32'h0000_0002};
    vecs[5] = '{32'h0000_0000, 0, 32'h0000_0000};
    trio[0] = '{32'h0000_0100, 0, 32'h0000_0200};
    trio[1] = '{32'h0000_0003, 0, 32'h0000_0006};
    trio[2] = '{32'hFFFF_FFFF, 0, 32'hFFFF_FFFE};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; num_taps = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(3);
    checkOutput("reset_ctrl", 64'({coef_addr, in_ready, out_valid, fir_cs, fir_write, fir_read, fir_addr, busy}), 0);
    checkOutput("reset_out_data", 64'(out_data), 0);
    checkOutput("reset_wdata", 64'(fir_wdata), 0);
    reset_n = 1'b1;
    tick(2);

    $display("[TB] coefficient load, 3 taps");
    checkCoefLoad3("coef3");

    $display("[TB] single sample latency, start while busy");
    bus_log.delete();
    out_ready = 1'b1;
    applyStimulus(32'h10, hs);
    start = 1'b1; num_taps = 5'd5;
    tick();
    start = 1'b0;
    tick(3);
    checkOutput("lat_no_early_valid", 64'(out_valid), 0);
    tick();
    checkOutput("lat_out", 64'({out_valid, out_data}), 64'({1'b1, 32'h20}));
    tick();
    checkOutput("lat_valid_drop", 64'(out_valid), 0);
    checkOutput("lat_in_ready_back", 64'(in_ready), 1);
    checkOutput("lat_nev", 64'(bus_log.size()), 2);
    checkEvent("lat_x_write", 0, hs, 1, 1'b0, 2'd1, 32'h10);
    checkEvent("lat_y_read", 1, hs, 4, 1'b1, 2'd1, 32'h0);

    $display("[TB] sample table with output stalls");
    for (int i = 0; i < 6; i++) begin
      out_ready = (vecs[i].stall == 0);
      applyStimulus(vecs[i].x, hs);
      waitOutValid($sformatf("vec%0d_valid_timeout", i));
      stable = 1'b1;
      for (int s = 0; s < vecs[i].stall; s++) begin
        if (out_valid !== 1'b1 || out_data !== vecs[i].y || in_ready !== 1'b0) stable = 1'b0;
        tick();
      end
      if (vecs[i].stall > 0) checkOutput($sformatf("vec%0d_stall_hold", i), 64'(stable), 1);
      checkOutput($sformatf("vec%0d_out", i), 64'({out_valid, out_data}), 64'({1'b1, vecs[i].y}));
      out_ready = 1'b1;
      tick();
      checkOutput($sformatf("vec%0d_valid_drop", i), 64'(out_valid), 0);
    end
`ifdef FIR_SEQ_CNT_EN
    checkOutput("sample_cnt_7", 64'(sample_cnt), 7);
`endif

    $display("[TB] stop pending while a sample is accepted");
    bus_log.delete();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    applyStimulus(32'h33, hs);
    waitOutValid("stopx_valid_timeout");
    checkOutput("stopx_out_data", 64'(out_data), 32'h66);
    waitIdle("stopx_idle_timeout");
    checkOutput("stopx_idle_cyc", 64'(cyc - hs), 9);
    tick();
    checkOutput("stopx_nev", 64'(bus_log.size()), 3);
    checkEvent("stopx_x_write", 0, hs, 1, 1'b0, 2'd1, 32'h33);
    checkEvent("stopx_y_read", 1, hs, 4, 1'b1, 2'd1, 32'h0);
    checkEvent("stopx_ctrl_off", 2, hs, 9, 1'b0, 2'd2, 32'h0);
`ifdef FIR_SEQ_CNT_EN
    checkOutput("sample_cnt_8", 64'(sample_cnt), 8);
`endif

    $display("[TB] stop during coefficient load");
    bus_log.delete();
    k = cyc;
    start = 1'b1; num_taps = 5'd2;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waitIdle("stopload_idle_timeout");
    checkOutput("stopload_idle_cyc", 64'(cyc - k), 8);
    tick();
    checkOutput("stopload_nev", 64'(bus_log.size()), 4);
    checkEvent("stopload_b0", 0, k, 3, 1'b0, 2'd0, 32'd5);
    checkEvent("stopload_b1", 1, k, 5, 1'b0, 2'd0, 32'd7);
    checkEvent("stopload_ctrl_on", 2, k, 6, 1'b0, 2'd2, 32'd1);
    checkEvent("stopload_ctrl_off", 3, k, 8, 1'b0, 2'd2, 32'd0);
`ifdef FIR_SEQ_CNT_EN
    checkOutput("sample_cnt_cleared", 64'(sample_cnt), 0);
`endif

    $display("[TB] zero taps, start and stop together, three samples");
    bus_log.delete();
    k = cyc;
    start = 1'b1; stop = 1'b1; num_taps = 5'd0;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(3);
    checkOutput("zt_busy", 64'(busy), 1);
    checkOutput("zt_in_ready", 64'(in_ready), 1);
    checkOutput("zt_nev", 64'(bus_log.size()), 1);
    checkEvent("zt_ctrl_on", 0, k, 2, 1'b0, 2'd2, 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(trio[i].x, hs);
      waitOutValid($sformatf("trio%0d_valid_timeout", i));
      checkOutput($sformatf("trio%0d_out_data", i), 64'(out_data), 64'(trio[i].y));
      tick();
    end
`ifdef FIR_SEQ_CNT_EN
    checkOutput("sample_cnt_3", 64'(sample_cnt), 3);
`endif
    stop = 1'b1;
    tick();
    stop = 1'b0;
    waitIdle("trio_idle_timeout");

    $display("[TB] reset in the middle of coefficient load");
    start = 1'b1; num_taps = 5'd3;
    tick();
    start = 1'b0;
    tick();
    bus_log.delete();
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_busy", 64'(busy), 0);
    tick();
    checkOutput("rst_ctrl", 64'({coef_addr, in_ready, out_valid, fir_cs, fir_write, fir_read, fir_addr, busy}), 0);
    checkOutput("rst_out_data", 64'(out_data), 0);
    tick();
    checkOutput("rst_no_bus", 64'(bus_log.size()), 0);
    reset_n = 1'b1;
    tick();
    checkCoefLoad3("reload");

    checkOutput("bus_protocol", 64'(prot_err), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
